// File: rtl/lsu_bus_bridge_if.sv
// Signal bundle between the core LSU, the bridge and the req/ack bus responder.
// The bridge drives the bus, so it uses the master modport; the environment side uses slave.
interface lsu_bus_bridge_if;
  logic [1:0]  MemWrite;
  logic [2:0]  SizeLoad;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  MemWrite, SizeLoad, Addr, WriteData, bus_ack, bus_rdata,
    output ReadData, Stall, Err, bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport slave (
    output MemWrite, SizeLoad, Addr, WriteData, bus_ack, bus_rdata,
    input  ReadData, Stall, Err, bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Single-outstanding load/store bridge from the core LSU to a req/ack bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking the low address bits.
//   state | meaning
//   IDLE  | waiting for a load/store request
//   BUSY  | bus_req held with latched address/data until bus_ack
//   DONE  | result (or trap) presented for one cycle, core released
module lsu_bus_bridge (
  input  logic             clk,
  input  logic             reset,
  lsu_bus_bridge_if.master lsu
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  ld_q, ld_d;
  logic [1:0]  off_q, off_d;
  logic        mis_q, mis_d;

  logic        ld_valid, req, mis;
  logic [1:0]  acc_size;
  logic [2:0]  ld_type;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // A store wins over a simultaneous load; load size comes from the low two bits of the load code.
  always_comb begin
    ld_valid = (lsu.SizeLoad inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110});
    req      = (lsu.MemWrite != 2'b00) || ld_valid;
    acc_size = 2'b00;
    ld_type  = 3'b000;
    if (lsu.MemWrite != 2'b00) begin
      acc_size = lsu.MemWrite;
    end else if (ld_valid) begin
      acc_size = lsu.SizeLoad[1:0];
      ld_type  = lsu.SizeLoad;
    end
    case (acc_size)
      2'b01: begin
        be    = 4'b0001 << lsu.Addr[1:0];
        wdata = {4{lsu.WriteData[7:0]}};
      end
      2'b10: begin
        be    = 4'b0011 << {lsu.Addr[1], 1'b0};
        wdata = {2{lsu.WriteData[15:0]}};
      end
      2'b11: begin
        be    = 4'b1111;
        wdata = lsu.WriteData;
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'd0;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((acc_size == 2'b10) && lsu.Addr[0]) ||
               ((acc_size == 2'b11) && (lsu.Addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    ld_d        = ld_q;
    off_d       = off_q;
    mis_d       = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          bus_we_d    = (lsu.MemWrite != 2'b00);
          bus_be_d    = be;
          bus_addr_d  = {lsu.Addr[31:2], 2'b00};
          bus_wdata_d = wdata;
          ld_d        = ld_type;
          off_d       = lsu.Addr[1:0];
          mis_d       = mis;
          if (mis) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_BUSY;
            bus_req_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (lsu.bus_ack) begin
          rdata_d   = lsu.bus_rdata;
          bus_req_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'b0000;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      ld_q        <= 3'b000;
      off_q       <= 2'b00;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      ld_q        <= ld_d;
      off_q       <= off_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = rdata_q[7:0];
      2'd1:    rd_byte = rdata_q[15:8];
      2'd2:    rd_byte = rdata_q[23:16];
      default: rd_byte = rdata_q[31:24];
    endcase
    rd_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    lsu.ReadData = 32'd0;
    if ((state_q == ST_DONE) && !mis_q) begin
      case (ld_q)
        3'b001:  lsu.ReadData = {{24{rd_byte[7]}}, rd_byte};
        3'b010:  lsu.ReadData = {{16{rd_half[15]}}, rd_half};
        3'b011:  lsu.ReadData = rdata_q;
        3'b101:  lsu.ReadData = {24'd0, rd_byte};
        3'b110:  lsu.ReadData = {16'd0, rd_half};
        default: lsu.ReadData = 32'd0;
      endcase
    end
  end

  assign lsu.Stall     = ((state_q == ST_IDLE) && req) || (state_q == ST_BUSY);
  assign lsu.bus_req   = bus_req_q;
  assign lsu.bus_we    = bus_we_q;
  assign lsu.bus_be    = bus_be_q;
  assign lsu.bus_addr  = bus_addr_q;
  assign lsu.bus_wdata = bus_wdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu.Err = (state_q == ST_DONE) && mis_q;
`else
  assign lsu.Err = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge: directed vector table, hand-written reset sequence, random accesses vs. a byte-level model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_bus_bridge;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lsu_bus_bridge_if io();

  lsu_bus_bridge dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mw;
    logic [2:0]  sl;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          wait_n;
    bit          spur;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] baddr;
    bit          we;
    logic [31:0] rdout;
    int          stall;
    bit          err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mw, input logic [2:0] sl, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int wn, input bit sp,
                              input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] baddr,
                              input bit we, input logic [31:0] rdout, input int stall, input bit err);
    vec_t v;
    v.mw = mw; v.sl = sl; v.addr = a; v.wd = wd; v.rd = rd; v.wait_n = wn; v.spur = sp;
    v.be = be; v.wdata = wdata; v.baddr = baddr; v.we = we; v.rdout = rdout;
    v.stall = stall; v.err = err;
    return v;
  endfunction

  // Byte-level reference: access size in bytes, lane offset and masking computed arithmetically.
  function automatic vec_t model(input logic [1:0] mw, input logic [2:0] sl, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int wn, input bit sp);
    vec_t        v;
    int          n, lane, off;
    bit          st, ld, sgn, trap;
    logic [63:0] mask, raw;
    st  = (mw != 2'b00);
    ld  = !st && (sl == 3'd1 || sl == 3'd2 || sl == 3'd3 || sl == 3'd5 || sl == 3'd6);
    if (st) n = (mw == 2'd1) ? 1 : (mw == 2'd2) ? 2 : 4;
    else    n = (sl == 3'd1 || sl == 3'd5) ? 1 : (sl == 3'd2 || sl == 3'd6) ? 2 : 4;
    sgn  = ld && (sl == 3'd1 || sl == 3'd2);
    off  = int'(a[1:0]);
    lane = (off / n) * n;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (st || ld) && ((off % n) != 0);
`else
    trap = 1'b0;
`endif
    v.mw = mw; v.sl = sl; v.addr = a; v.wd = wd; v.rd = rd; v.wait_n = wn; v.spur = sp;
    v.baddr = {a[31:2], 2'b00};
    v.be    = 4'(((1 << n) - 1) << lane);
    for (int i = 0; i < 4; i++) v.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    mask = (64'd1 << (8*n)) - 64'd1;
    raw  = ({32'd0, rd} >> (8*lane)) & mask;
    if (sgn && raw[8*n-1]) raw = raw | ~mask;
    v.rdout = (ld && !trap) ? raw[31:0] : 32'd0;
    v.we    = st;
    v.err   = trap;
    v.stall = !(st || ld) ? 0 : trap ? 1 : 2 + wn;
    return v;
  endfunction

  // Entered just after a rising edge with the DUT idle; returns the same way.
  task automatic do_access(input vec_t v, input int tag);
    int stall_cnt = 0;
    int busy_cyc  = 0;
    bit done      = 0;
    bit ack_prev  = 0;
    bit ack_now;
    string t;
    t = $sformatf("#%0d", tag);
    io.MemWrite  = v.mw;
    io.SizeLoad  = v.sl;
    io.Addr      = v.addr;
    io.WriteData = v.wd;
    io.bus_ack   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      ack_now      = (io.bus_req && busy_cyc == v.wait_n) || (v.spur && ack_prev);
      io.bus_ack   = ack_now;
      io.bus_rdata = !ack_now ? $urandom : (ack_prev ? 32'hBAD0_BAD0 : v.rd);
      ack_prev     = ack_now;
      @(negedge clk);
      if (io.Stall) begin
        chk({"err_stall", t}, io.Err, 1'b0);
        if (cyc == 0) begin
          chk({"req_idle", t}, io.bus_req, 1'b0);
        end else begin
          chk({"req_busy", t}, io.bus_req, 1'b1);
          chk({"addr", t}, io.bus_addr, v.baddr);
          chk({"be", t}, io.bus_be, v.be);
          chk({"we", t}, io.bus_we, v.we);
          if (v.we) chk({"wdata", t}, io.bus_wdata, v.wdata);
        end
        stall_cnt++;
        if (io.bus_req) busy_cyc++;
      end else begin
        chk({"rdata", t}, io.ReadData, v.rdout);
        chk({"err", t}, io.Err, v.err);
        chk({"req_done", t}, io.bus_req, 1'b0);
        done = 1;
      end
      @(posedge clk); #1;
      io.bus_ack = 1'b0;
    end
    io.MemWrite = 2'b00;
    io.SizeLoad = 3'b000;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout%s actual=no_release required=release", t);
    end
    chk({"stall_cycles", t}, stall_cnt, v.stall);
    io.bus_ack = v.spur;
    @(negedge clk);
    chk({"post_stall", t}, io.Stall, 1'b0);
    chk({"post_rdata", t}, io.ReadData, 32'd0);
    @(posedge clk); #1;
    io.bus_ack = 1'b0;
    @(negedge clk);
    chk({"post_req", t}, io.bus_req, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    clk = 0; checks = 0; errors = 0;
    reset = 1;
    io.MemWrite = 0; io.SizeLoad = 0; io.Addr = 0; io.WriteData = 0;
    io.bus_ack = 0; io.bus_rdata = 0;

    tbl.push_back(mk(2'b11, 3'd0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1004, 1, 32'h0, 2, 0));
    tbl.push_back(mk(2'b01, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, 1, 32'h0, 2, 0));
    tbl.push_back(mk(2'b00, 3'd1, 32'h0000_2002, 32'h0, 32'h1280_5634, 0, 0, 4'b0100, 32'h0, 32'h0000_2000, 0, 32'hFFFF_FF80, 2, 0));
    tbl.push_back(mk(2'b00, 3'd5, 32'h0000_2002, 32'h0, 32'h1280_5634, 1, 0, 4'b0100, 32'h0, 32'h0000_2000, 0, 32'h0000_0080, 3, 0));
    tbl.push_back(mk(2'b00, 3'd2, 32'h0000_2002, 32'h0, 32'h1280_5634, 0, 0, 4'b1100, 32'h0, 32'h0000_2000, 0, 32'h0000_1280, 2, 0));
    tbl.push_back(mk(2'b00, 3'd3, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 4, 1, 4'b1111, 32'h0, 32'h0000_2000, 0, 32'hCAFE_F00D, 6, 0));
    tbl.push_back(mk(2'b00, 3'd6, 32'h0000_2000, 32'h0, 32'h1234_F00D, 0, 0, 4'b0011, 32'h0, 32'h0000_2000, 0, 32'h0000_F00D, 2, 0));
    tbl.push_back(mk(2'b00, 3'd2, 32'h0000_2000, 32'h0, 32'h1234_F00D, 2, 0, 4'b0011, 32'h0, 32'h0000_2000, 0, 32'hFFFF_F00D, 4, 0));
    tbl.push_back(mk(2'b10, 3'd0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, 1, 32'h0, 2, 0));
    tbl.push_back(mk(2'b01, 3'd3, 32'h0000_0001, 32'h0000_005A, 32'h7777_7777, 0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0000_0000, 1, 32'h0, 2, 0));
    tbl.push_back(mk(2'b00, 3'd4, 32'h0000_0008, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(2'b00, 3'd0, 32'h0000_000C, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(2'b00, 3'd3, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 0, 4'b1111, 32'h0, 32'h0000_3000, 0, 32'h0, 1, 1));
    tbl.push_back(mk(2'b10, 3'd0, 32'h0000_2003, 32'h0000_BEEF, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, 1, 32'h0, 1, 1));
`else
    tbl.push_back(mk(2'b00, 3'd3, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 0, 4'b1111, 32'h0, 32'h0000_3000, 0, 32'h1122_3344, 2, 0));
    tbl.push_back(mk(2'b10, 3'd0, 32'h0000_2003, 32'h0000_BEEF, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, 1, 32'h0, 2, 0));
`endif

    // Outputs while held in reset with no request.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", io.bus_req, 1'b0);
    chk("rst_be", io.bus_be, 4'b0000);
    chk("rst_addr", io.bus_addr, 32'd0);
    chk("rst_stall", io.Stall, 1'b0);
    chk("rst_rdata", io.ReadData, 32'd0);
    chk("rst_err", io.Err, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // Reset in the middle of a word load; the late ack must not complete anything.
    io.SizeLoad = 3'd3; io.Addr = 32'h0000_4000; io.WriteData = 32'h5555_AAAA;
    @(negedge clk);
    chk("mid_idle_stall", io.Stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy_req", io.bus_req, 1'b1);
    #2 reset = 1;
    #1;
    chk("mid_rst_req", io.bus_req, 1'b0);
    chk("mid_rst_we", io.bus_we, 1'b0);
    chk("mid_rst_be", io.bus_be, 4'b0000);
    chk("mid_rst_addr", io.bus_addr, 32'd0);
    chk("mid_rst_wdata", io.bus_wdata, 32'd0);
    chk("mid_rst_rdata", io.ReadData, 32'd0);
    chk("mid_rst_err", io.Err, 1'b0);
    chk("mid_rst_stall_req", io.Stall, 1'b1);
    io.SizeLoad = 3'd0;
    #1;
    chk("mid_rst_stall_noreq", io.Stall, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    io.bus_ack = 1; io.bus_rdata = 32'h8765_4321;
    @(negedge clk);
    chk("late_ack_req", io.bus_req, 1'b0);
    chk("late_ack_stall", io.Stall, 1'b0);
    @(posedge clk); #1;
    io.bus_ack = 0;
    @(negedge clk);
    chk("late_ack_rdata", io.ReadData, 32'd0);
    chk("late_ack_req2", io.bus_req, 1'b0);
    @(posedge clk); #1;

    foreach (tbl[i]) do_access(tbl[i], i);

    for (int k = 0; k < 300; k++) begin
      logic [1:0]  mw;
      logic [2:0]  sl;
      logic [31:0] a;
      mw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sl = 3'($urandom);
      a  = $urandom;
      do_access(model(mw, sl, a, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom)), 100 + k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
